// File: rtl/pal_pkg.sv
// rtl/pal_pkg.sv - shared limits and width helper for the serial palindrome detector
package pal_pkg;

    localparam int WIN_MIN = 2;
    localparam int WIN_MAX = 32;

    // Width of the fill counter, which runs 0..win-1.
    function automatic int fill_width(input int win);
        return $clog2(win);
    endfunction

    typedef enum logic {
        FILLING = 1'b0,
        ARMED   = 1'b1
    } det_state_t;

endpackage

// File: rtl/pal_check.sv
// rtl/pal_check.sv - combinational palindrome test of a WIN-bit window
module pal_check #(
    parameter int WIN = 3
) (
    input  logic [WIN-1:0] w,
    output logic           pal
);

    logic [WIN-1:0] eq;

    // Every bit is compared with its mirror; the odd-length centre compares with itself.
    for (genvar i = 0; i < WIN; i++) begin : g_mirror
        assign eq[i] = ~(w[i] ^ w[WIN-1-i]);
    end

    assign pal = &eq;

endmodule

// File: rtl/serial_palindrome_detector.sv
// rtl/serial_palindrome_detector.sv - Mealy detector of palindromic WIN-bit windows in a bit stream
module serial_palindrome_detector
    import pal_pkg::*;
#(
    parameter int WIN   = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din_valid,
    input  logic             din,
    input  logic             overlap,
    input  logic             clear,
    output logic             match,
    output logic             match_q,
    output logic [CNT_W-1:0] match_cnt,
    output logic             armed
);

    localparam int FW = fill_width(WIN);
    localparam logic [FW-1:0] FILL_MAX = FW'(WIN - 1);
    localparam logic [FW-1:0] FILL_PRE = FW'(WIN - 2);

    if (WIN < WIN_MIN || WIN > WIN_MAX) begin : g_bad_win
        $error("serial_palindrome_detector: WIN out of range");
    end

    logic [WIN-2:0] hist;
    logic [FW-1:0]  fill;
    det_state_t     state;
    logic [WIN-1:0] w;
    logic           pal;

    assign w     = {hist, din};
    assign armed = (state == ARMED);
    assign match = din_valid & armed & pal & ~clear;

    pal_check #(.WIN(WIN)) u_pal_check (
        .w   (w),
        .pal (pal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist      <= '0;
            fill      <= '0;
            state     <= FILLING;
            match_q   <= 1'b0;
            match_cnt <= '0;
        end else begin
            match_q <= match;
            if (clear) begin
                fill      <= '0;
                state     <= FILLING;
                match_cnt <= '0;
                match_q   <= 1'b0;
            end else if (din_valid) begin
                hist <= w[WIN-2:0];
                // Non-overlapping mode: the old history is stale and must be refilled.
                if (match && !overlap) begin
                    fill  <= '0;
                    state <= FILLING;
                end else if (fill != FILL_MAX) begin
                    fill  <= fill + 1'b1;
                    state <= (fill == FILL_PRE) ? ARMED : FILLING;
                end
                if (match && match_cnt != {CNT_W{1'b1}}) begin
                    match_cnt <= match_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_palindrome_detector.sv
// tb/tb_serial_palindrome_detector.sv - randomized self-checking bench against a queue-based reference model
module tb_serial_palindrome_detector;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic din_valid = 1'b0;
    logic din = 1'b0;
    logic overlap = 1'b1;
    logic clear = 1'b0;

    logic       match_v [3];
    logic       match_q_v [3];
    logic       armed_v [3];
    logic [7:0] cnt0;
    logic [7:0] cnt1;
    logic [1:0] cnt2;

    int checks = 0;
    int failures = 0;

    // Instance 0: WIN=3/CNT_W=8, instance 1: WIN=4/CNT_W=8, instance 2: WIN=3/CNT_W=2
    const int win  [3] = '{3, 4, 3};
    const int cmax [3] = '{255, 255, 3};

    bit hq [3][$];
    int cnt [3];
    bit mqe [3];

    always #5 clk = ~clk;

    serial_palindrome_detector #(.WIN(3), .CNT_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .overlap(overlap),
        .clear(clear), .match(match_v[0]), .match_q(match_q_v[0]), .match_cnt(cnt0),
        .armed(armed_v[0])
    );

    serial_palindrome_detector #(.WIN(4), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .overlap(overlap),
        .clear(clear), .match(match_v[1]), .match_q(match_q_v[1]), .match_cnt(cnt1),
        .armed(armed_v[1])
    );

    serial_palindrome_detector #(.WIN(3), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .overlap(overlap),
        .clear(clear), .match(match_v[2]), .match_q(match_q_v[2]), .match_cnt(cnt2),
        .armed(armed_v[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_cnt(input int k);
        if (k == 0) return {24'd0, cnt0};
        if (k == 1) return {24'd0, cnt1};
        return {30'd0, cnt2};
    endfunction

    function automatic bit m_armed(input int k);
        return hq[k].size() >= win[k] - 1;
    endfunction

    // Window = last win-1 accepted bits plus the new one; palindrome iff equal to its reverse.
    function automatic bit m_pal(input int k, input bit d);
        bit wq[$];
        int n = win[k];
        for (int i = hq[k].size() - (n - 1); i < hq[k].size(); i++) wq.push_back(hq[k][i]);
        wq.push_back(d);
        for (int i = 0; i < n; i++) if (wq[i] != wq[n-1-i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            hq[k].delete();
            cnt[k] = 0;
            mqe[k] = 1'b0;
        end
    endtask

    task automatic cycle(input bit v, input bit d, input bit ov, input bit clr);
        bit em [3];
        @(negedge clk);
        din_valid = v;
        din = d;
        overlap = ov;
        clear = clr;
        #1;
        for (int k = 0; k < 3; k++) begin
            em[k] = v && !clr && m_armed(k) && m_pal(k, d);
            check($sformatf("armed%0d", k), {31'd0, armed_v[k]}, {31'd0, m_armed(k)});
            check($sformatf("match%0d", k), {31'd0, match_v[k]}, {31'd0, em[k]});
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (clr) begin
                hq[k].delete();
                cnt[k] = 0;
                mqe[k] = 1'b0;
            end else begin
                mqe[k] = em[k];
                if (v) begin
                    if (em[k] && !ov) begin
                        hq[k].delete();
                    end else begin
                        hq[k].push_back(d);
                        if (hq[k].size() > win[k] - 1) void'(hq[k].pop_front());
                    end
                    if (em[k] && cnt[k] < cmax[k]) cnt[k]++;
                end
            end
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("match_q%0d", k), {31'd0, match_q_v[k]}, {31'd0, mqe[k]});
            check($sformatf("match_cnt%0d", k), dut_cnt(k), cnt[k]);
        end
    endtask

    task automatic stream(input logic [7:0] bits, input int n, input bit ov);
        for (int i = n - 1; i >= 0; i--) cycle(1'b1, bits[i], ov, 1'b0);
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #2;
        din_valid = 1'b1;
        din = 1'b1;
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_match%0d", k), {31'd0, match_v[k]}, 32'd0);
            check($sformatf("rst_armed%0d", k), {31'd0, armed_v[k]}, 32'd0);
            check($sformatf("rst_cnt%0d", k), dut_cnt(k), 32'd0);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #12;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("init_match%0d", k), {31'd0, match_v[k]}, 32'd0);
            check($sformatf("init_match_q%0d", k), {31'd0, match_q_v[k]}, 32'd0);
            check($sformatf("init_armed%0d", k), {31'd0, armed_v[k]}, 32'd0);
            check($sformatf("init_cnt%0d", k), dut_cnt(k), 32'd0);
        end
        #5;
        rst_n = 1'b1;

        stream(8'b01010, 5, 1'b1);
        check("t1_cnt", dut_cnt(0), 32'd3);

        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        stream(8'b010, 3, 1'b0);
        check("t2_armed_after", {31'd0, armed_v[0]}, 32'd0);
        stream(8'b10, 2, 1'b0);
        check("t2_cnt", dut_cnt(0), 32'd1);

        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        stream(8'b11, 2, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        check("t3_cnt", dut_cnt(0), 32'd1);

        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        stream(8'b1001, 4, 1'b1);
        check("t4_cnt_win4", dut_cnt(1), 32'd1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        stream(8'b1010, 4, 1'b1);
        check("t4_nomatch_win4", dut_cnt(1), 32'd0);

        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        stream(8'b000000, 6, 1'b1);
        check("t5_sat_cnt2", dut_cnt(2), 32'd3);
        check("t5_cnt0", dut_cnt(0), 32'd4);

        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        stream(8'b10, 2, 1'b1);
        mid_reset();
        stream(8'b101, 3, 1'b1);
        check("t6_cnt", dut_cnt(0), 32'd1);

        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        stream(8'b01, 2, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        check("t6_clear_cnt", dut_cnt(0), 32'd0);

        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(3, 0) != 0), $urandom_range(1, 0) == 1,
                  ($urandom_range(7, 0) != 0), ($urandom_range(49, 0) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
